// File: rtl/led_nios2_qsys_mul_seq_pkg.sv
// Shared definitions for the multi-cycle 32x32 multiply sequencer.
// Contents:
//   DATA_W / HALF_W : operand width and partial-product operand width
//   OP_*            : operation encodings carried on the op port
//   ST_*            : sequencer state encodings
package led_nios2_qsys_mul_seq_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

  // Operation select
  localparam logic [1:0] OP_MUL    = 2'd0;  // low word of the product
  localparam logic [1:0] OP_MULXUU = 2'd1;  // high word, unsigned x unsigned
  localparam logic [1:0] OP_MULXSU = 2'd2;  // high word, signed src1 x unsigned src2
  localparam logic [1:0] OP_MULXSS = 2'd3;  // high word, signed x signed

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_FIX   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/led_nios2_qsys_mul_seq_pp.sv
// Registered unsigned HALF_W x HALF_W multiplier (one cycle latency).
// Intended to map onto a single dedicated hardware multiplier.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset, clears the product register
//   a, b    : unsigned operands
//   p       : registered product of the operands presented on the previous cycle
module led_nios2_qsys_mul_seq_pp #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [HALF_W-1:0]     a,
  input  logic [HALF_W-1:0]     b,
  output logic [2*HALF_W-1:0]   p
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p <= '0;
    end else begin
      p <= a * b;
    end
  end

endmodule

// File: rtl/led_nios2_qsys_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer. One registered 16x16 unsigned
// multiplier is reused for four partial products; the 64-bit unsigned sum is
// then sign-corrected in its upper word for the signed high-word ops.
// Fixed latency: accept at edge E, done high in the cycle after edge E+6.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   start   : request, sampled only in IDLE
//   op      : 0=MUL, 1=MULXUU, 2=MULXSU, 3=MULXSS
//   src1    : multiplicand
//   src2    : multiplier
//   flush   : abandon current operation / block acceptance in IDLE
//   busy    : high from the cycle after accept through the done cycle
//   done    : one-cycle pulse, result valid in the same cycle
//   result  : selected product word, held until the next done
module led_nios2_qsys_mul_seq #(
  parameter int DATA_W = led_nios2_qsys_mul_seq_pkg::DATA_W,
  parameter int HALF_W = led_nios2_qsys_mul_seq_pkg::HALF_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  import led_nios2_qsys_mul_seq_pkg::*;

  logic [2:0]          state_reg;
  logic [1:0]          cnt_reg;
  logic [1:0]          op_reg;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [2*DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0]   result_reg;

  logic [HALF_W-1:0]   pp_a;
  logic [HALF_W-1:0]   pp_b;
  logic [DATA_W-1:0]   pp_p;
  logic [2*DATA_W-1:0] addend;
  logic [DATA_W-1:0]   hi_corr;
  logic [DATA_W-1:0]   hi_fixed;

  // cnt bit 0 picks the half of a, bit 1 the half of b:
  // 0: lo*lo, 1: hi*lo, 2: lo*hi, 3: hi*hi
  always_comb begin
    pp_a = cnt_reg[0] ? a_reg[DATA_W-1:HALF_W] : a_reg[HALF_W-1:0];
    pp_b = cnt_reg[1] ? b_reg[DATA_W-1:HALF_W] : b_reg[HALF_W-1:0];
  end

  led_nios2_qsys_mul_seq_pp #(
    .HALF_W (HALF_W)
  ) u_pp (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (pp_a),
    .b       (pp_b),
    .p       (pp_p)
  );

  // The multiplier output lags issue by one cycle, so in ISSUE cycle cnt the
  // product on pp_p belongs to index cnt-1; nothing is valid yet at cnt=0.
  // The hi*hi product arrives during DRAIN.
  always_comb begin
    addend = '0;
    if (state_reg == ST_ISSUE) begin
      case (cnt_reg)
        2'd1:       addend = {{DATA_W{1'b0}}, pp_p};
        2'd2, 2'd3: addend = {{HALF_W{1'b0}}, pp_p, {HALF_W{1'b0}}};
        default:    addend = '0;
      endcase
    end else if (state_reg == ST_DRAIN) begin
      addend = {pp_p, {DATA_W{1'b0}}};
    end
  end

  // Signed high word = unsigned high word minus the other operand for each
  // operand treated as signed whose sign bit is set (mod 2^32).
  always_comb begin
    hi_corr = '0;
    if ((op_reg == OP_MULXSU || op_reg == OP_MULXSS) && a_reg[DATA_W-1]) begin
      hi_corr = hi_corr + b_reg;
    end
    if (op_reg == OP_MULXSS && b_reg[DATA_W-1]) begin
      hi_corr = hi_corr + a_reg;
    end
    hi_fixed = acc_reg[2*DATA_W-1:DATA_W] - hi_corr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else if (flush && state_reg != ST_IDLE) begin
      // A flush in DONE still lets the current done pulse through, since
      // done is decoded from the state already being left.
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !flush) begin
            a_reg     <= src1;
            b_reg     <= src2;
            op_reg    <= op;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          acc_reg <= acc_reg + addend;
          cnt_reg <= cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          acc_reg   <= acc_reg + addend;
          state_reg <= ST_FIX;
        end
        ST_FIX: begin
          acc_reg[2*DATA_W-1:DATA_W] <= hi_fixed;
          result_reg <= (op_reg == OP_MUL) ? acc_reg[DATA_W-1:0] : hi_fixed;
          state_reg  <= ST_DONE;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_reg != ST_IDLE);
  assign done   = (state_reg == ST_DONE);
  assign result = result_reg;

endmodule

// File: doc/led_nios2_qsys_mul_seq.md
Name: led_nios2_qsys_mul_seq

Overview:
- Multi-cycle 32x32 multiply sequencer in the Nios II execute path. It sits directly downstream of the operand/decode stage and works alongside the mult cell.
- Covers what the mult cell does not: full 64-bit product with selectable signedness.
- Returns either the low word (mul) or the high word (mulxuu / mulxsu / mulxss) after a fixed latency.
- Built from one registered 16x16 unsigned partial-product multiplier, reused over four cycles, plus an accumulator and a sign-correction step.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- HALF_W, 16, partial-product operand width; must equal DATA_W/2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  0=MUL (low word), 1=MULXUU, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXSS
- src1  input  32  multiplicand
- src2  input  32  multiplier
- flush  input  1  pipeline kill; abandons the current operation
- busy  output  1  high from the cycle after accept until done, inclusive
- done  output  1  one-cycle pulse; result is valid in the same cycle
- result  output  32  selected product word; holds its value until the next done

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. Reset clears state to IDLE, busy=0, done=0, result=0, and clears the accumulator, counter and operand registers.
- States: IDLE, ISSUE, DRAIN, FIX, DONE.
- IDLE:
  - start=1 and flush=0 accepts the request.
  - On accept, latch src1, src2 and op; clear the 64-bit accumulator; set cnt=0; go to ISSUE.
- ISSUE (4 cycles, cnt=0..3):
  - Drive the partial-product multiplier with unsigned halves. cnt0=a.lo*b.lo, cnt1=a.hi*b.lo, cnt2=a.lo*b.hi, cnt3=a.hi*b.hi.
  - The multiplier output is registered (1-cycle latency). In each cycle, the product issued in the previous cycle is added to the accumulator, shifted left by 0, 16, 16 or 32 respectively.
  - After cnt=3, go to DRAIN.
- DRAIN: accumulate the cnt3 product. Go to FIX.
- FIX: apply the sign correction to accumulator bits [63:32], modulo 2^32:
  - MULXSU: subtract src2 if src1[31]=1.
  - MULXSS: additionally subtract src1 if src2[31]=1.
  - MUL and MULXUU: no correction.
  - Go to DONE.
- DONE:
  - Assert done for exactly one cycle.
  - result = acc[31:0] for MUL, otherwise acc[63:32].
  - Return to IDLE.
- Latency: accept at edge E; done is high in the cycle after edge E+6, i.e. 7 cycles. This is fixed for all ops.
- Throughput: a new start is accepted no earlier than the cycle in which done is high plus one (IDLE).
- start while busy is ignored and not queued.
- A change on src1/src2/op after accept has no effect.
- flush:
  - In any non-IDLE state, flush forces IDLE on the next edge. busy and done go low, result is unchanged, and no done is issued.
  - flush in IDLE blocks acceptance that cycle.
  - flush in the DONE cycle does not suppress that done pulse.
- Arithmetic: the accumulator is 64 bits unsigned. The partial sum never overflows 64 bits, and overflow above bit 63 is discarded.
- Async reset mid-operation: immediate return to reset values; no done for the interrupted op.

Decomposition:
- Shared package holds:
  - op encodings MUL/MULXUU/MULXSU/MULXSS.
  - state encoding.
  - DATA_W/HALF_W constants.
- One sub-module: led_nios2_qsys_mul_seq_pp, a registered 16x16 unsigned multiplier. It has clk, reset_n, a, b and a 32-bit product with 1-cycle latency, mapped to the dedicated multiplier.

Test Plan:
- MUL and MULXUU with src1=0x00010000, src2=0x00010000 -> MUL result=0x00000000; MULXUU result=0x00000001. done exactly 7 cycles after accept; busy high for cycles 1..7.
- src1=src2=0xFFFFFFFF -> MUL=0x00000001, MULXUU=0xFFFFFFFE, MULXSU=0xFFFFFFFF, MULXSS=0x00000000.
- MULXSS 0x80000000*0x80000000 -> 0x40000000; MULXSS 0x7FFFFFFF*0x80000000 -> 0xC0000000.
- Start while busy: second start at cycle 3 with different operands -> ignored, first result returned. Back-to-back: start held high -> next accept in the IDLE cycle after done, results correct.
- flush at cycle 3 of MULXUU -> busy low next cycle, no done pulse, result holds its previous value. Subsequent MUL 3*5 -> 0x0000000F.
- reset_n low in the FIX cycle -> busy=0, done=0, result=0 immediately. After release, MULXUU 0xFFFFFFFF*2 -> 0x00000001.
